// File: rtl/hop_pkg.sv
// hop_pkg: shared constants and types for the hop input generator.
//   hop_mode_e  - link-state hop mode encodings (matches the hop_mode port)
//   eng_state_e - F/F' engine states
//   page_x()    - page/inquiry X before response freezing
package hop_pkg;

    localparam logic [6:0] NCHAN  = 7'd79;
    localparam logic [4:0] KOFF_A = 5'd24;
    localparam logic [4:0] KOFF_B = 5'd8;
    localparam int         MODW   = 25;

    typedef enum logic [2:0] {
        MODE_CONN  = 3'd0,
        MODE_PSCAN = 3'd1,
        MODE_ISCAN = 3'd2,
        MODE_PAGE  = 3'd3,
        MODE_INQ   = 3'd4,
        MODE_SRESP = 3'd5,
        MODE_MRESP = 3'd6,
        MODE_IRESP = 3'd7
    } hop_mode_e;

    typedef enum logic {
        ENG_IDLE = 1'b0,
        ENG_CALC = 1'b1
    } eng_state_e;

    // hi = CLK[16:12], lo = {CLK[4:2], CLK[0]}.
    // The mod-16 term only needs the low nibble of hi; the final sum wraps mod 32.
    function automatic logic [4:0] page_x(input logic [4:0] hi, input logic [3:0] lo,
                                          input logic [4:0] koff);
        logic [3:0] d;
        d = lo - hi[3:0];
        return hi + koff + {1'b0, d};
    endfunction

endpackage

// File: rtl/hop_modseq.sv
// hop_modseq: keeps F = 16*CLK[27:7] mod 79 and F' = 16*CLK[27:7] mod N.
//   clk, rst      - clock, synchronous active-high reset
//   clk_tick      - btclk advanced this cycle
//   btclk         - Bluetooth clock
//   resync        - recompute F/F' from scratch
//   afh_modn      - N (20..79); a change also forces a recompute
//   f, fprime     - current F / F'
//   hop_valid     - F/F' consistent with btclk
// A full recompute is a restoring shift-subtract over {CLK[27:7],4'b0}, both
// moduli in parallel. Between recomputes, each 128-slot boundary adds 16.
module hop_modseq
    import hop_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_tick,
    input  logic [27:0] btclk,
    input  logic        resync,
    input  logic [6:0]  afh_modn,
    output logic [6:0]  f,
    output logic [6:0]  fprime,
    output logic        hop_valid
);

    eng_state_e      state, state_nxt;
    logic [MODW-1:0] div_q;
    logic [4:0]      cnt_q;
    logic [6:0]      r79_q, rn_q, r79_step, rn_step;
    logic [6:0]      m_q, modn_q;
    logic            pend_q;
    logic            tick_upd, wrap, start, last, load, finish;
    logic [7:0]      f_sum, fp_sum;
    logic [6:0]      f_inc, fp_inc;

    // One restoring step: shift in a dividend bit, subtract the modulus once.
    // r < m on entry, so {r,b} < 2m and a single subtract suffices.
    function automatic logic [6:0] mod_step(input logic [6:0] r, input logic b,
                                            input logic [6:0] m);
        logic [7:0] t;
        t = {r, b};
        if (t >= {1'b0, m}) t = t - {1'b0, m};
        return t[6:0];
    endfunction

    assign tick_upd = clk_tick && (btclk[6:0] == 7'd0);
    assign wrap     = (btclk[27:7] == 21'd0);
    assign start    = resync || (afh_modn != modn_q);
    assign last     = (cnt_q == 5'(MODW - 1));
    assign r79_step = mod_step(r79_q, div_q[MODW-1], NCHAN);
    assign rn_step  = mod_step(rn_q,  div_q[MODW-1], m_q);

    // Incremental +16; N >= 20 keeps a single conditional subtract exact.
    always_comb begin
        f_sum  = {1'b0, f} + 8'd16;
        fp_sum = {1'b0, fprime} + 8'd16;
        f_inc  = (f_sum  >= {1'b0, NCHAN}) ? 7'(f_sum  - {1'b0, NCHAN}) : f_sum[6:0];
        fp_inc = (fp_sum >= {1'b0, m_q})   ? 7'(fp_sum - {1'b0, m_q})   : fp_sum[6:0];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ENG_IDLE;
        else     state <= state_nxt;
    end

    // A boundary tick seen during CALC (or on its last cycle) makes the
    // result stale, so the divide restarts from the current btclk.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        finish    = 1'b0;
        case (state)
            ENG_IDLE: begin
                if (start) begin
                    state_nxt = ENG_CALC;
                    load      = 1'b1;
                end
            end
            ENG_CALC: begin
                if (start || (last && (pend_q || tick_upd))) begin
                    load = 1'b1;
                end else if (last) begin
                    state_nxt = ENG_IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = ENG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            cnt_q     <= '0;
            r79_q     <= '0;
            rn_q      <= '0;
            m_q       <= afh_modn;
            modn_q    <= afh_modn;
            pend_q    <= 1'b0;
            f         <= '0;
            fprime    <= '0;
            hop_valid <= 1'b0;
        end else begin
            modn_q <= afh_modn;
            if (load) begin
                div_q     <= {btclk[27:7], 4'b0};
                cnt_q     <= '0;
                r79_q     <= '0;
                rn_q      <= '0;
                m_q       <= afh_modn;
                pend_q    <= 1'b0;
                hop_valid <= 1'b0;
            end else if (state == ENG_CALC) begin
                div_q <= div_q << 1;
                r79_q <= r79_step;
                rn_q  <= rn_step;
                cnt_q <= cnt_q + 5'd1;
                if (tick_upd) pend_q <= 1'b1;
                if (finish) begin
                    f         <= r79_step;
                    fprime    <= rn_step;
                    hop_valid <= 1'b1;
                end
            end else if (tick_upd) begin
                f      <= wrap ? 7'd0 : f_inc;
                fprime <= wrap ? 7'd0 : fp_inc;
            end
        end
    end

endmodule

// File: rtl/hop_input_gen.sv
// hop_input_gen: builds the hop-kernel control words for every hop mode.
//   clk, rst        - clock, synchronous active-high reset
//   clk_tick        - btclk advanced this cycle
//   btclk           - CLKN/CLKE[27:0]
//   bd_addr         - {UAP[3:0], LAP[23:0]} (GIAC for inquiry scan)
//   hop_mode        - hop_mode_e encoding
//   afh_en          - connection mode uses the adapted set (F' path)
//   scan_interlace  - add 16 to scan X
//   train_rep       - trains per koffset toggle (0 acts as 1)
//   afh_modn        - N, used-channel count
//   resync          - recompute F/F'
//   X,Y1,Y2,A..E    - registered kernel inputs
//   F, Fprime       - F/F' (zero outside connection mode; Fprime also zero without AFH)
//   hop_valid       - F/F' consistent with btclk
module hop_input_gen
    import hop_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_tick,
    input  logic [27:0] btclk,
    input  logic [27:0] bd_addr,
    input  logic [2:0]  hop_mode,
    input  logic        afh_en,
    input  logic        scan_interlace,
    input  logic [9:0]  train_rep,
    input  logic [6:0]  afh_modn,
    input  logic        resync,
    output logic [4:0]  X,
    output logic        Y1,
    output logic [5:0]  Y2,
    output logic [4:0]  A,
    output logic [3:0]  B,
    output logic [4:0]  C,
    output logic [8:0]  D,
    output logic [6:0]  E,
    output logic [6:0]  F,
    output logic [6:0]  Fprime,
    output logic        hop_valid
);

    hop_mode_e  mode, mode_q;
    logic       is_page, is_resp, entry, page_tick, resp_tick;
    logic [9:0] rep_eff, tcnt_q, tcnt_nxt;
    logic [4:0] koff_q, koff_nxt, base_q, base_nxt, n_q, n_nxt;
    logic [4:0] x_nxt, a_nxt, c_nxt;
    logic [3:0] b_nxt;
    logic [8:0] d_nxt;
    logic [6:0] e_nxt;
    logic       y1_nxt, fsel_q, fpsel_q;
    logic [6:0] f_eng, fp_eng;

    assign mode      = hop_mode_e'(hop_mode);
    assign is_page   = (mode == MODE_PAGE) || (mode == MODE_INQ);
    assign is_resp   = (mode == MODE_SRESP) || (mode == MODE_MRESP) || (mode == MODE_IRESP);
    assign entry     = (mode != mode_q);
    assign page_tick = clk_tick && (btclk[4:0] == 5'd0);
    assign resp_tick = clk_tick && (btclk[1:0] == 2'd0);
    assign rep_eff   = (train_rep == 10'd0) ? 10'd1 : train_rep;

    // Train offset and response counter; all X paths use the next-state
    // values so every output lands one clock after its cause.
    always_comb begin
        koff_nxt = koff_q;
        tcnt_nxt = tcnt_q;
        if (is_page) begin
            if (entry) begin
                koff_nxt = KOFF_A;
                tcnt_nxt = '0;
            end else if (page_tick) begin
                if (tcnt_q + 10'd1 >= rep_eff) begin
                    koff_nxt = (koff_q == KOFF_A) ? KOFF_B : KOFF_A;
                    tcnt_nxt = '0;
                end else begin
                    tcnt_nxt = tcnt_q + 10'd1;
                end
            end
        end

        base_nxt = base_q;
        n_nxt    = n_q;
        if (is_resp) begin
            if (entry) begin
                // Master response continues the page X it was answering.
                base_nxt = (mode == MODE_MRESP)
                         ? page_x(btclk[16:12], {btclk[4:2], btclk[0]}, koff_q)
                         : btclk[16:12];
                n_nxt    = '0;
            end else if (resp_tick) begin
                n_nxt = n_q + 5'd1;
            end
        end else begin
            base_nxt = '0;
            n_nxt    = '0;
        end
    end

    always_comb begin
        a_nxt  = bd_addr[27:23];
        b_nxt  = bd_addr[22:19];
        c_nxt  = {bd_addr[8], bd_addr[6], bd_addr[4], bd_addr[2], bd_addr[0]};
        d_nxt  = bd_addr[18:10];
        e_nxt  = {bd_addr[13], bd_addr[11], bd_addr[9], bd_addr[7],
                  bd_addr[5], bd_addr[3], bd_addr[1]};
        x_nxt  = '0;
        y1_nxt = 1'b0;
        case (mode)
            MODE_CONN: begin
                x_nxt  = btclk[6:2];
                y1_nxt = btclk[1];
                a_nxt  = a_nxt ^ btclk[25:21];
                c_nxt  = c_nxt ^ btclk[20:16];
                d_nxt  = d_nxt ^ btclk[15:7];
            end
            MODE_PSCAN, MODE_ISCAN: begin
                x_nxt = btclk[16:12] + (scan_interlace ? 5'd16 : 5'd0);
            end
            MODE_PAGE, MODE_INQ: begin
                x_nxt  = page_x(btclk[16:12], {btclk[4:2], btclk[0]}, koff_nxt);
                y1_nxt = btclk[1];
            end
            default: begin
                x_nxt  = base_nxt + n_nxt;
                y1_nxt = btclk[1];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_CONN;
            koff_q  <= KOFF_A;
            tcnt_q  <= '0;
            base_q  <= '0;
            n_q     <= '0;
            fsel_q  <= 1'b0;
            fpsel_q <= 1'b0;
            X       <= '0;
            Y1      <= 1'b0;
            A       <= '0;
            B       <= '0;
            C       <= '0;
            D       <= '0;
            E       <= '0;
        end else begin
            mode_q  <= mode;
            koff_q  <= koff_nxt;
            tcnt_q  <= tcnt_nxt;
            base_q  <= base_nxt;
            n_q     <= n_nxt;
            fsel_q  <= (mode == MODE_CONN);
            fpsel_q <= (mode == MODE_CONN) && afh_en;
            X       <= x_nxt;
            Y1      <= y1_nxt;
            A       <= a_nxt;
            B       <= b_nxt;
            C       <= c_nxt;
            D       <= d_nxt;
            E       <= e_nxt;
        end
    end

    assign Y2     = {Y1, 5'b0};
    assign F      = fsel_q  ? f_eng  : 7'd0;
    assign Fprime = fpsel_q ? fp_eng : 7'd0;

    hop_modseq u_modseq (
        .clk       (clk),
        .rst       (rst),
        .clk_tick  (clk_tick),
        .btclk     (btclk),
        .resync    (resync),
        .afh_modn  (afh_modn),
        .f         (f_eng),
        .fprime    (fp_eng),
        .hop_valid (hop_valid)
    );

endmodule

// File: tb/tb_hop_input_gen.sv
// Bench for hop_input_gen: table of stateless field vectors, hand sequences
// for train/response/engine corner cases, and randomized connection-mode
// ticks checked against arithmetic reference values.
module tb_hop_input_gen;

    logic        clk = 1'b0, rst = 1'b1, clk_tick = 1'b0;
    logic [27:0] btclk = '0, bd_addr = '0;
    logic [2:0]  hop_mode = 3'd0;
    logic        afh_en = 1'b1, scan_interlace = 1'b0, resync = 1'b0;
    logic [9:0]  train_rep = 10'd1;
    logic [6:0]  afh_modn = 7'd20;
    logic [4:0]  X, A, C;
    logic        Y1, hop_valid;
    logic [5:0]  Y2;
    logic [3:0]  B;
    logic [8:0]  D;
    logic [6:0]  E, F, Fprime;

    int checks = 0, errors = 0;

    hop_input_gen dut (
        .clk(clk), .rst(rst), .clk_tick(clk_tick), .btclk(btclk), .bd_addr(bd_addr),
        .hop_mode(hop_mode), .afh_en(afh_en), .scan_interlace(scan_interlace),
        .train_rep(train_rep), .afh_modn(afh_modn), .resync(resync),
        .X(X), .Y1(Y1), .Y2(Y2), .A(A), .B(B), .C(C), .D(D), .E(E),
        .F(F), .Fprime(Fprime), .hop_valid(hop_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  mode;
        logic [27:0] clkv;
        logic        il;
        logic [4:0]  x;
        logic        y1;
    } vec_t;
    vec_t tbl[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [27:0] v);
        btclk    = v;
        clk_tick = 1'b1;
        step();
        clk_tick = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (hop_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("hop_valid_timeout", 64'(ok), 64'd1);
    endtask

    // Reference A/B/C/D/E packed as {A,B,C,D,E}, built bit by bit from the address.
    function automatic logic [29:0] m_fields(input int addr, input int clkv, input bit conn);
        int a, b, c, d, e;
        a = (addr >> 23) & 31;
        b = (addr >> 19) & 15;
        d = (addr >> 10) & 511;
        c = 0;
        e = 0;
        for (int i = 0; i < 5; i++) c |= ((addr >> (2 * i)) & 1) << i;
        for (int i = 0; i < 7; i++) e |= ((addr >> (2 * i + 1)) & 1) << i;
        if (conn) begin
            a ^= (clkv >> 21) & 31;
            c ^= (clkv >> 16) & 31;
            d ^= (clkv >> 7) & 511;
        end
        return {a[4:0], b[3:0], c[4:0], d[8:0], e[6:0]};
    endfunction

    initial begin
        int k, n, off;

        tbl[0] = '{3'd0, 28'h000007C, 1'b0, 5'd31, 1'b0};
        tbl[1] = '{3'd0, 28'h0000042, 1'b0, 5'd16, 1'b1};
        tbl[2] = '{3'd1, 28'h0014000, 1'b1, 5'd4,  1'b0};
        tbl[3] = '{3'd2, 28'h0014002, 1'b0, 5'd20, 1'b0};
        tbl[4] = '{3'd3, 28'h0003015, 1'b0, 5'd3,  1'b0};
        tbl[5] = '{3'd4, 28'h0003017, 1'b0, 5'd3,  1'b1};
        tbl[6] = '{3'd3, 28'h0000000, 1'b0, 5'd24, 1'b0};
        tbl[7] = '{3'd3, 28'h001F01D, 1'b0, 5'd23, 1'b0};

        // Reset state
        step();
        step();
        chk("reset_outputs", 64'({X, Y1, Y2, A, B, C, D, E, F, Fprime, hop_valid}), 64'd0);
        rst = 1'b0;

        // Stateless field vectors
        for (int i = 0; i < 8; i++) begin
            hop_mode       = tbl[i].mode;
            btclk          = tbl[i].clkv;
            scan_interlace = tbl[i].il;
            bd_addr        = 28'($urandom);
            step();
            chk($sformatf("tbl%0d_xy", i), 64'({X, Y1, Y2}), 64'({tbl[i].x, tbl[i].y1, tbl[i].y1, 5'd0}));
            chk($sformatf("tbl%0d_fields", i), 64'({A, B, C, D, E}),
                64'(m_fields(int'(bd_addr), int'(btclk), tbl[i].mode == 3'd0)));
        end
        scan_interlace = 1'b0;

        // Connection resync, CLK[27:7]=5
        hop_mode = 3'd0; bd_addr = '0; afh_modn = 7'd20; btclk = 28'h280;
        resync = 1'b1; step(); resync = 1'b0;
        wait_valid(40);
        chk("t1_f_fp_x", 64'({F, Fprime, X}), 64'({7'd1, 7'd0, 5'd0}));

        // Incremental updates and wrap
        tick(28'h300);
        chk("t2_inc", 64'({F, Fprime}), 64'({7'd17, 7'd16}));
        tick(28'h0FFFFFFF);
        chk("t2_nonboundary", 64'({F, Fprime}), 64'({7'd17, 7'd16}));
        tick(28'h0);
        chk("t2_wrap", 64'({F, Fprime}), 64'd0);
        tick(28'h80);
        chk("t2_after_wrap", 64'({F, Fprime, hop_valid}), 64'({7'd16, 7'd16, 1'b1}));

        // Page trains
        hop_mode = 3'd3; train_rep = 10'd2; btclk = 28'h3015;
        step();
        chk("t3_entry_x", 64'(X), 64'd3);
        tick(28'h3005);
        tick(28'h3000);
        tick(28'h3020);
        btclk = 28'h3015; step();
        chk("t3_koffB_x", 64'(X), 64'd19);
        tick(28'h3040);
        tick(28'h3060);
        btclk = 28'h3015; step();
        chk("t3_koffA_x", 64'(X), 64'd3);
        train_rep = 10'd0;
        tick(28'h3080);
        btclk = 28'h3015; step();
        chk("t3_rep0_x", 64'(X), 64'd19);

        // Response modes
        hop_mode = 3'd5; btclk = 28'hA000; step();
        chk("t4_sresp_entry", 64'(X), 64'd10);
        tick(28'hA004);
        tick(28'hA008);
        tick(28'hA00D);
        tick(28'hA00C);
        chk("t4_sresp_n3", 64'(X), 64'd13);
        btclk = 28'h1F000; step();
        chk("t4_sresp_frozen", 64'(X), 64'd13);
        hop_mode = 3'd6; btclk = 28'h3015; step();
        chk("t4_mresp_entry", 64'(X), 64'd19);
        tick(28'h3014);
        chk("t4_mresp_n1", 64'({X, Y1}), 64'({5'd20, 1'b0}));
        hop_mode = 3'd7; btclk = 28'h5000; step();
        chk("t4_iresp_entry", 64'(X), 64'd5);

        // Randomized connection mode against modular arithmetic
        hop_mode = 3'd0;
        n = $urandom_range(79, 20);
        k = $urandom_range(32'h1FFFFF, 0);
        afh_modn = 7'(n);
        btclk = 28'(k << 7);
        resync = 1'b1; step(); resync = 1'b0;
        wait_valid(40);
        chk("rnd_start", 64'({F, Fprime}), 64'({7'((16 * k) % 79), 7'((16 * k) % n)}));
        for (int i = 0; i < 40; i++) begin
            k = (k + 1) & 32'h1FFFFF;
            bd_addr = 28'($urandom);
            tick(28'(k << 7));
            chk($sformatf("rnd%0d_f", i), 64'({F, Fprime, hop_valid}),
                64'({7'((16 * k) % 79), 7'((16 * k) % n), 1'b1}));
            chk($sformatf("rnd%0d_fields", i), 64'({A, B, C, D, E}),
                64'(m_fields(int'(bd_addr), int'(btclk), 1'b1)));
            off = $urandom_range(127, 1);
            tick(28'((k << 7) | off));
            chk($sformatf("rnd%0d_mid", i), 64'({F, Fprime, X, Y1}),
                64'({7'((16 * k) % 79), 7'((16 * k) % n), 5'((off >> 2) & 31), 1'((off >> 1) & 1)}));
        end

        // Scan with interlace: F/F' forced to zero
        hop_mode = 3'd1; btclk = 28'h14000; scan_interlace = 1'b1; step();
        chk("t5_scan", 64'({X, Y1, F, Fprime}), 64'({5'd4, 1'b0, 7'd0, 7'd0}));
        scan_interlace = 1'b0;

        // afh_modn change recomputes
        hop_mode = 3'd0; btclk = 28'h300; afh_modn = 7'd50; step();
        chk("modn_invalid", 64'(hop_valid), 64'd0);
        wait_valid(40);
        chk("modn_result", 64'({F, Fprime}), 64'({7'd17, 7'd46}));

        // Boundary tick during CALC forces a rerun
        btclk = 28'h280;
        resync = 1'b1; step(); resync = 1'b0;
        for (int i = 0; i < 5; i++) step();
        tick(28'h300);
        for (int i = 0; i < 21; i++) step();
        chk("t6_pending_invalid", 64'(hop_valid), 64'd0);
        wait_valid(60);
        chk("t6_rerun", 64'({F, Fprime}), 64'({7'd17, 7'd46}));

        // Reset mid-CALC
        resync = 1'b1; step(); resync = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1; step();
        chk("t6_rst_outputs", 64'({X, Y1, Y2, A, B, C, D, E, F, Fprime, hop_valid}), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) step();
        chk("t6_rst_idle", 64'(hop_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
